// File: rtl/exec_ctrl_if.sv
// exec_ctrl_if
//   Bundles the sequencer's control and status signals between the core-side
//   environment (master) and the execution sequencer (slave).
//   master drives: run_sw, step_n, bp_en, bp_addr, pc
//   slave  drives: cpu_en, state, halted, icount
interface exec_ctrl_if #(
    parameter int PC_W = 32
);
    logic            run_sw;   // raw run switch, level, asynchronous
    logic            step_n;   // raw step button, active-low, bouncy
    logic            bp_en;    // breakpoint enable
    logic [PC_W-1:0] bp_addr;  // breakpoint PC
    logic [PC_W-1:0] pc;       // current PC from the core
    logic            cpu_en;   // execute-this-cycle strobe
    logic [1:0]      state;    // 00 IDLE, 01 RUN, 10 STEP, 11 BRK
    logic            halted;   // IDLE or BRK
    logic [15:0]     icount;   // executed-instruction counter

    modport master (
        output run_sw, step_n, bp_en, bp_addr, pc,
        input  cpu_en, state, halted, icount
    );

    modport slave (
        input  run_sw, step_n, bp_en, bp_addr, pc,
        output cpu_en, state, halted, icount
    );
endinterface

// File: rtl/exec_ctrl.sv
// exec_ctrl
//   Execution sequencer for the single-cycle core. Generates a one-cycle
//   clock-enable (cpu_en) for PC, register file and data memory, in free-run
//   mode at one instruction every DIV cycles, single-step mode from a
//   debounced push-button, and halts on a PC breakpoint.
// Ports
//   clk   : system clock
//   rst   : asynchronous reset, active-low
//   bus   : exec_ctrl_if.slave (run_sw, step_n, bp_en, bp_addr, pc in;
//           cpu_en, state, halted, icount out)
module exec_ctrl #(
    parameter int DIV       = 50_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int PC_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    exec_ctrl_if.slave  bus
);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_BRK  = 2'b11
    } state_t;

    // Synchronisers
    logic run_meta_q, run_meta_d, run_s_q, run_s_d;
    logic step_meta_q, step_meta_d, step_s_q, step_s_d;

    // Debouncer
    logic            db_stable_q, db_stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            step_pulse;

    // Sequencer
    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      icount_q, icount_d;

    logic [PC_W-1:0] pc_l, bp_addr_l;
    logic            bp_hit, tick, cpu_en;

    assign pc_l      = bus.pc;
    assign bp_addr_l = bus.bp_addr;
    assign bp_hit    = bus.bp_en & (pc_l == bp_addr_l);
    assign tick      = (pre_q == PRE_MAX);

    // Strobe is formed from registered state only; a breakpoint tick is
    // swallowed so the breakpoint instruction itself is not executed.
    assign cpu_en = (state_q == ST_STEP) |
                    ((state_q == ST_RUN) & run_s_q & tick & ~bp_hit);

    always_comb begin
        run_meta_d  = bus.run_sw;
        run_s_d     = run_meta_q;
        step_meta_d = bus.step_n;
        step_s_d    = step_meta_q;

        // Counter only runs while the input disagrees with the accepted
        // level; any return to the accepted level restarts the wait.
        db_stable_d = db_stable_q;
        db_cnt_d    = '0;
        if (step_s_q != db_stable_q) begin
            if (db_cnt_q == DB_MAX) begin
                db_stable_d = step_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        // Press (1->0) only; release is silent.
        step_pulse = db_stable_q & ~db_stable_d;

        state_d = state_q;
        pre_d   = pre_q;
        case (state_q)
            ST_IDLE: begin
                if (run_s_q) begin
                    state_d = ST_RUN;
                    pre_d   = '0;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!run_s_q) begin
                    // Stop wins over a coincident tick.
                    state_d = ST_IDLE;
                    pre_d   = '0;
                end else if (tick) begin
                    pre_d = '0;
                    if (bp_hit) state_d = ST_BRK;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            ST_BRK: begin
                if (!run_s_q) begin
                    state_d = ST_IDLE;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
            end
        endcase

        icount_d = cpu_en ? (icount_q + 16'd1) : icount_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_meta_q  <= 1'b0;
            run_s_q     <= 1'b0;
            step_meta_q <= 1'b1;
            step_s_q    <= 1'b1;
            db_stable_q <= 1'b1;
            db_cnt_q    <= '0;
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            icount_q    <= '0;
        end else begin
            run_meta_q  <= run_meta_d;
            run_s_q     <= run_s_d;
            step_meta_q <= step_meta_d;
            step_s_q    <= step_s_d;
            db_stable_q <= db_stable_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            pre_q       <= pre_d;
            icount_q    <= icount_d;
        end
    end

    assign bus.cpu_en = cpu_en;
    assign bus.state  = state_q;
    assign bus.halted = (state_q == ST_IDLE) | (state_q == ST_BRK);
    assign bus.icount = icount_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl
//   Bench for exec_ctrl with DIV=4, DB_CYCLES=3. A small core model advances
//   pc by 4 on each cpu_en. Expected strobe times come from the run rules:
//   with run_sw high before reset release, the first strobe is 6 cycles after
//   release (2 sync + IDLE->RUN + prescaler 0..3), then every 4 cycles.
module tb_exec_ctrl;
    localparam int DIV = 4;
    localparam int FIRST = 6;

    logic clk;
    logic rst;
    logic pc_clear;
    int   n_checks;
    int   n_fail;

    exec_ctrl_if #(.PC_W(32)) bus ();

    exec_ctrl #(.DIV(DIV), .DB_CYCLES(3), .PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core PC model
    always @(posedge clk) begin
        if (pc_clear)        bus.pc <= 32'h0;
        else if (bus.cpu_en) bus.pc <= bus.pc + 32'd4;
    end

    always @(negedge clk) begin
        if (rst && bus.cpu_en)
            $display("strobe pc=%08h icount=%0d state=%0d", bus.pc, bus.icount, bus.state);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic bit run_strobe(input int k);
        return (k >= FIRST) && (((k - FIRST) % DIV) == 0);
    endfunction

    task automatic hold_reset(input logic run);
        rst          = 1'b0;
        pc_clear     = 1'b1;
        bus.run_sw   = run;
        bus.step_n   = 1'b1;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = 32'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        rst      = 1'b1;
        pc_clear = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset(1'b1);
        bus.step_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en got=%b exp=0", bus.cpu_en); end
            if (bus.state !== 2'b00) begin n_fail++; $display("FAIL reset_state got=%b exp=00", bus.state); end
            if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted got=%b exp=1", bus.halted); end
            if (bus.icount !== 16'h0) begin n_fail++; $display("FAIL reset_icount got=%0d exp=0", bus.icount); end
        end
        $display("test_reset done");
    endtask

    task automatic test_run();
        hold_reset(1'b1);
        release_reset();
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.cpu_en !== run_strobe(k)) begin
                n_fail++; $display("FAIL run_cpu_en k=%0d got=%b exp=%b", k, bus.cpu_en, run_strobe(k));
            end
        end
        n_checks += 3;
        if (bus.icount !== 16'd5) begin n_fail++; $display("FAIL run_icount got=%0d exp=5", bus.icount); end
        if (bus.pc !== 32'h14) begin n_fail++; $display("FAIL run_pc got=%h exp=14", bus.pc); end
        if (bus.state !== 2'b01) begin n_fail++; $display("FAIL run_state got=%b exp=01", bus.state); end
        $display("test_run done");
    endtask

    task automatic test_random_stop();
        for (int it = 0; it < 4; it++) begin
            int n;
            int exp_cnt;
            n = $urandom_range(8, 40);
            exp_cnt = 0;
            hold_reset(1'b1);
            release_reset();
            for (int k = 1; k <= n + 3; k++) begin
                bit e;
                if (k == n + 1) bus.run_sw = 1'b0;
                @(negedge clk);
                // run_sw drop reaches run_s two edges later, gating cpu_en.
                e = run_strobe(k) && (k <= n + 1);
                if (e) exp_cnt++;
                n_checks++;
                if (bus.cpu_en !== e) begin
                    n_fail++; $display("FAIL stop_cpu_en n=%0d k=%0d got=%b exp=%b", n, k, bus.cpu_en, e);
                end
            end
            n_checks += 3;
            if (bus.state !== 2'b00) begin n_fail++; $display("FAIL stop_state n=%0d got=%b exp=00", n, bus.state); end
            if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL stop_halted n=%0d got=%b exp=1", n, bus.halted); end
            if (bus.icount !== 16'(exp_cnt)) begin
                n_fail++; $display("FAIL stop_icount n=%0d got=%0d exp=%0d", n, bus.icount, exp_cnt);
            end
            $display("test_random_stop n=%0d strobes=%0d", n, exp_cnt);
        end
    endtask

    task automatic test_breakpoint(input int m);
        logic [31:0] bp;
        bp = 32'(4 * m);
        hold_reset(1'b1);
        bus.bp_en   = 1'b1;
        bus.bp_addr = bp;
        release_reset();
        for (int k = 1; k <= FIRST + DIV * m; k++) begin
            bit e;
            @(negedge clk);
            e = run_strobe(k) && (k < FIRST + DIV * m);
            n_checks++;
            if (bus.cpu_en !== e) begin
                n_fail++; $display("FAIL bp_cpu_en bp=%h k=%0d got=%b exp=%b", bp, k, bus.cpu_en, e);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks += 3;
            if (bus.state !== 2'b11) begin n_fail++; $display("FAIL bp_state bp=%h got=%b exp=11", bp, bus.state); end
            if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL bp_halted bp=%h got=%b exp=1", bp, bus.halted); end
            if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold_cpu_en bp=%h got=%b exp=0", bp, bus.cpu_en); end
        end
        n_checks += 2;
        if (bus.icount !== 16'(m)) begin n_fail++; $display("FAIL bp_icount bp=%h got=%0d exp=%0d", bp, bus.icount, m); end
        if (bus.pc !== bp) begin n_fail++; $display("FAIL bp_pc got=%h exp=%h", bus.pc, bp); end
        $display("test_breakpoint bp=%h", bp);
    endtask

    // Runs from the BRK state left by test_breakpoint, run_sw still high.
    task automatic test_step_past_bp(input int m);
        logic [31:0] bp;
        int s;
        int strobes;
        bp = 32'(4 * m);
        s = -1;
        strobes = 0;
        bus.step_n = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            if (t == 7) bus.step_n = 1'b1;
            @(negedge clk);
            if (bus.cpu_en) strobes++;
            if (s < 0) begin
                if (bus.cpu_en) begin
                    s = t;
                    n_checks += 2;
                    if (bus.pc !== bp) begin n_fail++; $display("FAIL step_pc got=%h exp=%h", bus.pc, bp); end
                    if (bus.state !== 2'b10) begin n_fail++; $display("FAIL step_state got=%b exp=10", bus.state); end
                end
            end else begin
                int d;
                d = t - s;
                n_checks++;
                if (bus.cpu_en !== (d == 5)) begin
                    n_fail++; $display("FAIL step_resume_cpu_en d=%0d got=%b exp=%b", d, bus.cpu_en, (d == 5));
                end
                if (d == 1) begin
                    n_checks++;
                    if (bus.state !== 2'b00) begin n_fail++; $display("FAIL step_idle got=%b exp=00", bus.state); end
                end
                if (d == 2) begin
                    n_checks++;
                    if (bus.state !== 2'b01) begin n_fail++; $display("FAIL step_run got=%b exp=01", bus.state); end
                end
                if (d == 5) begin
                    n_checks++;
                    if (bus.pc !== bp + 32'd4) begin n_fail++; $display("FAIL step_resume_pc got=%h exp=%h", bus.pc, bp + 32'd4); end
                    break;
                end
            end
        end
        n_checks++;
        if (s < 0) begin n_fail++; $display("FAIL step_timeout got=no_strobe exp=strobe"); end
        else if (strobes !== 2) begin n_fail++; $display("FAIL step_strobes got=%0d exp=2", strobes); end
        @(negedge clk);
        n_checks++;
        if (bus.icount !== 16'(m + 2)) begin n_fail++; $display("FAIL step_icount got=%0d exp=%0d", bus.icount, m + 2); end
        bus.run_sw = 1'b0;
        repeat (6) @(negedge clk);
        $display("test_step_past_bp first_strobe=%0d", s);
    endtask

    task automatic test_bounce();
        int strobes;
        hold_reset(1'b0);
        release_reset();
        repeat (4) @(negedge clk);
        // Toggle every cycle, end high, then sub-threshold low glitches.
        for (int t = 0; t < 30; t++) begin
            if (t < 20)       bus.step_n = t[0];
            else if (t < 22)  bus.step_n = 1'b0;
            else if (t == 22) bus.step_n = 1'b1;
            else              bus.step_n = ($urandom_range(0, 2) == 0) ? 1'b0 : ~bus.step_n | 1'b1;
            if (t >= 23 && t[0] == 1'b0) bus.step_n = 1'b1;
            @(negedge clk);
            n_checks += 2;
            if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL bounce_cpu_en t=%0d got=%b exp=0", t, bus.cpu_en); end
            if (bus.state !== 2'b00) begin n_fail++; $display("FAIL bounce_state t=%0d got=%b exp=00", t, bus.state); end
        end
        bus.step_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            n_checks++;
            if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL bounce_tail_cpu_en t=%0d got=%b exp=0", t, bus.cpu_en); end
        end
        n_checks++;
        if (bus.icount !== 16'h0) begin n_fail++; $display("FAIL bounce_icount got=%0d exp=0", bus.icount); end
        // A clean press from IDLE is accepted exactly once.
        strobes = 0;
        bus.step_n = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (t == 6) bus.step_n = 1'b1;
            @(negedge clk);
            if (bus.cpu_en) strobes++;
        end
        n_checks += 3;
        if (strobes !== 1) begin n_fail++; $display("FAIL press_strobes got=%0d exp=1", strobes); end
        if (bus.icount !== 16'd1) begin n_fail++; $display("FAIL press_icount got=%0d exp=1", bus.icount); end
        if (bus.state !== 2'b00) begin n_fail++; $display("FAIL press_state got=%b exp=00", bus.state); end
        $display("test_bounce done");
    endtask

    task automatic test_reset_mid_run();
        hold_reset(1'b1);
        release_reset();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.cpu_en !== run_strobe(k)) begin
                n_fail++; $display("FAIL midrst_pre_cpu_en k=%0d got=%b exp=%b", k, bus.cpu_en, run_strobe(k));
            end
        end
        #2 rst = 1'b0;
        #1;
        n_checks += 4;
        if (bus.cpu_en !== 1'b0) begin n_fail++; $display("FAIL midrst_cpu_en got=%b exp=0", bus.cpu_en); end
        if (bus.state !== 2'b00) begin n_fail++; $display("FAIL midrst_state got=%b exp=00", bus.state); end
        if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL midrst_halted got=%b exp=1", bus.halted); end
        if (bus.icount !== 16'h0) begin n_fail++; $display("FAIL midrst_icount got=%0d exp=0", bus.icount); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.cpu_en !== run_strobe(k)) begin
                n_fail++; $display("FAIL midrst_post_cpu_en k=%0d got=%b exp=%b", k, bus.cpu_en, run_strobe(k));
            end
        end
        n_checks++;
        if (bus.icount !== 16'd1) begin n_fail++; $display("FAIL midrst_post_icount got=%0d exp=1", bus.icount); end
        $display("test_reset_mid_run done");
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        pc_clear    = 1'b1;
        bus.run_sw  = 1'b0;
        bus.step_n  = 1'b1;
        bus.bp_en   = 1'b0;
        bus.bp_addr = 32'h0;
        test_reset();
        test_run();
        test_random_stop();
        test_breakpoint($urandom_range(0, 6));
        test_breakpoint(4);
        test_step_past_bp(4);
        test_bounce();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
